// File: rtl/four_bit_adder_gate_lvl.sv
// four_bit_adder_gate_lvl
// 4-bit unsigned ripple-carry adder built from xor/and/or gate primitives,
// with a registered sum and carry-out (one cycle of latency, one op per cycle).
// Optional feature macro: FOUR_BIT_ADDER_OVF_EN adds the registered signed-overflow
// output ovf (carry into MSB xor carry out of MSB). Without it the port list is
// exactly clk, rst, A, B, sum, cout.
// Reset is synchronous and active-high; it takes priority over the captured sum.
module four_bit_adder_gate_lvl (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
`ifdef FOUR_BIT_ADDER_OVF_EN
    output logic       ovf,
`endif
    output logic [3:0] sum,
    output logic       cout
);

    // Ripple carry chain: carry_s[i] is the carry into bit i, carry_s[4] is the carry out.
    logic [4:0] carry_s;
    logic [3:0] sum_s;
    logic [3:0] half_s;   // a ^ b per cell
    logic [3:0] gen_s;    // a & b per cell
    logic [3:0] prop_s;   // ci & (a ^ b) per cell

    logic [3:0] sum_r;
    logic       cout_r;

    assign carry_s[0] = 1'b0;

    // Four full-adder cells, each from gate primitives only:
    //   s  = a ^ b ^ ci
    //   co = (a & b) | (ci & (a ^ b))
    for (genvar i = 0; i < 4; i++) begin : g_fa
        xor u_x1 (half_s[i], A[i], B[i]);
        xor u_x2 (sum_s[i], half_s[i], carry_s[i]);
        and u_a1 (gen_s[i], A[i], B[i]);
        and u_a2 (prop_s[i], carry_s[i], half_s[i]);
        or  u_o1 (carry_s[i+1], gen_s[i], prop_s[i]);
    end

    // Output register for sum and carry-out; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= 4'b0000;
            cout_r <= 1'b0;
        end else begin
            sum_r  <= sum_s;
            cout_r <= carry_s[4];
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

`ifdef FOUR_BIT_ADDER_OVF_EN
    // Two's-complement overflow: carry into the MSB differs from carry out of it.
    logic ovf_s;
    logic ovf_r;

    xor u_ovf (ovf_s, carry_s[3], carry_s[4]);

    // Overflow flag register, same latency and reset behaviour as the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_s;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_four_bit_adder_gate_lvl.sv
// Self-checking bench for four_bit_adder_gate_lvl: directed vectors, boundary
// cases, exhaustive sweep, back-to-back random vectors and mid-stream reset.
module tb_four_bit_adder_gate_lvl;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] sum;
    logic       cout;
`ifdef FOUR_BIT_ADDER_OVF_EN
    logic       ovf;
`endif

    int pass_cnt;
    int total_cnt;

    four_bit_adder_gate_lvl dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
`ifdef FOUR_BIT_ADDER_OVF_EN
        .ovf  (ovf),
`endif
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for signed overflow of a 4-bit two's-complement add.
    function automatic logic ref_ovf(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        r = {1'b0, a} + {1'b0, b};
        return (a[3] == b[3]) && (r[3] != a[3]);
    endfunction

    // Apply one operand pair, clock it in, then compare the registered result.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp, input logic exp_ovf);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        total_cnt++;
        assert ({cout, sum} === exp) pass_cnt++;
        else $error("FAIL %s: A=%h B=%h observed {cout,sum}=%b expected %b",
                    tag, a, b, {cout, sum}, exp);
`ifdef FOUR_BIT_ADDER_OVF_EN
        total_cnt++;
        assert (ovf === exp_ovf) pass_cnt++;
        else $error("FAIL %s_ovf: A=%h B=%h observed ovf=%b expected %b",
                    tag, a, b, ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unexpected X in overflow expectation");
`endif
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        pass_cnt  = 0;
        total_cnt = 0;

        // Reset held for two edges with max operands present.
        rst = 1'b1;
        step("reset0", 4'hF, 4'hF, 5'b00000, 1'b0);
        step("reset1", 4'hF, 4'hF, 5'b00000, 1'b0);
        rst = 1'b0;

        // Directed vectors with hand-computed results.
        step("zero",  4'h0, 4'h0, 5'b00000, 1'b0);
        step("1p1",   4'h1, 4'h1, 5'b00010, 1'b0);
        step("3p3",   4'h3, 4'h3, 5'b00110, 1'b0);
        step("7p7",   4'h7, 4'h7, 5'b01110, 1'b1);
        step("7p1",   4'h7, 4'h1, 5'b01000, 1'b1);
        step("FpF",   4'hF, 4'hF, 5'b11110, 1'b0);
        step("Fp1",   4'hF, 4'h1, 5'b10000, 1'b0);
        step("8p8",   4'h8, 4'h8, 5'b10000, 1'b1);
        step("Ap5",   4'hA, 4'h5, 5'b01111, 1'b0);
        step("0p0b",  4'h0, 4'h0, 5'b00000, 1'b0);

        // Exhaustive sweep of all 256 operand pairs, back to back.
        for (int i = 0; i < 256; i++) begin
            ra = 4'(i >> 4);
            rb = 4'(i);
            step("sweep", ra, rb, {1'b0, ra} + {1'b0, rb}, ref_ovf(ra, rb));
        end

        // 1000 random back-to-back vectors.
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            step("random", ra, rb, {1'b0, ra} + {1'b0, rb}, ref_ovf(ra, rb));
        end

        // Mid-stream reset clears outputs at the next edge; release reloads A+B.
        step("pre_rst", 4'h9, 4'h9, 5'b10010, 1'b1);
        rst = 1'b1;
        step("mid_rst", 4'hC, 4'h6, 5'b00000, 1'b0);
        rst = 1'b0;
        step("post_rst", 4'hC, 4'h6, 5'b10010, 1'b0);
        step("post_rst2", 4'h4, 4'h5, 5'b01001, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
